// File: rtl/coreaxi4sram_chan_slice.sv
// Single-channel AXI4 valid/ready register slice for CoreAXI4SRAM.
// MODE 0 is a wire-through, MODE 1 registers the forward path, MODE 2 is a two-entry skid buffer.
module coreaxi4sram_chan_slice #(
  parameter int PAYLOAD_WIDTH = 73,
  parameter int MODE          = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     S_VALID,
  output logic                     S_READY,
  input  logic [PAYLOAD_WIDTH-1:0] S_PAYLOAD,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [PAYLOAD_WIDTH-1:0] M_PAYLOAD,
  output logic [1:0]               OCCUPANCY
);

  generate
    if (MODE == 0) begin : g_bypass

      assign M_VALID   = S_VALID;
      assign S_READY   = M_READY;
      assign M_PAYLOAD = S_PAYLOAD;
      assign OCCUPANCY = 2'd0;

      wire unused_clk_rst = &{1'b0, ACLK, ARESETN};

    end else if (MODE == 1) begin : g_fwd

      logic                     init_q;
      logic                     valid_q, valid_d;
      logic [PAYLOAD_WIDTH-1:0] data_q, data_d;
      logic                     up;

      // Ready is combinational from M_READY: the stage frees up in the same cycle it drains.
      assign S_READY = init_q & (~valid_q | M_READY);
      assign up      = S_VALID & S_READY;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up) begin
          valid_d = 1'b1;
          data_d  = S_PAYLOAD;
        end else if (M_READY) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          init_q  <= 1'b0;
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          init_q  <= 1'b1;
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign M_VALID   = valid_q;
      assign M_PAYLOAD = data_q;
      assign OCCUPANCY = {1'b0, valid_q};

    end else begin : g_skid

      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
      } state_e;

      state_e                   state_q;
      logic                     s_ready_q;
      logic                     m_valid_q;
      logic [1:0]               occ_q;
      logic [PAYLOAD_WIDTH-1:0] main_q;
      logic [PAYLOAD_WIDTH-1:0] skid_q;
      logic                     up;
      logic                     down;

      assign up   = S_VALID & s_ready_q;
      assign down = m_valid_q & M_READY;

      // s_ready_q is low only while the skid entry is occupied (and before the first edge after reset).
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          state_q   <= ST_EMPTY;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          occ_q     <= 2'd0;
          main_q    <= '0;
          skid_q    <= '0;
        end else begin
          s_ready_q <= 1'b1;
          case (state_q)
            ST_EMPTY: begin
              if (up) begin
                main_q    <= S_PAYLOAD;
                m_valid_q <= 1'b1;
                occ_q     <= 2'd1;
                state_q   <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (up && down) begin
                main_q <= S_PAYLOAD;
              end else if (down) begin
                m_valid_q <= 1'b0;
                occ_q     <= 2'd0;
                state_q   <= ST_EMPTY;
              end else if (up) begin
                skid_q    <= S_PAYLOAD;
                s_ready_q <= 1'b0;
                occ_q     <= 2'd2;
                state_q   <= ST_FULL;
              end
            end
            ST_FULL: begin
              if (down) begin
                main_q  <= skid_q;
                occ_q   <= 2'd1;
                state_q <= ST_ONE;
              end else begin
                s_ready_q <= 1'b0;
              end
            end
            default: begin
              m_valid_q <= 1'b0;
              occ_q     <= 2'd0;
              state_q   <= ST_EMPTY;
            end
          endcase
        end
      end

      assign S_READY   = s_ready_q;
      assign M_VALID   = m_valid_q;
      assign M_PAYLOAD = main_q;
      assign OCCUPANCY = occ_q;

    end
  endgenerate

endmodule

// File: tb/tb_coreaxi4sram_chan_slice.sv
// Directed bench for coreaxi4sram_chan_slice: one instance per MODE, shared clock and reset.
module tb_coreaxi4sram_chan_slice;

  localparam int PW = 16;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          m_ready;
  logic [PW-1:0] s_payload;

  logic          s_ready1, m_valid1;
  logic [PW-1:0] m_payload1;
  logic [1:0]    occ1;
  logic          s_ready2, m_valid2;
  logic [PW-1:0] m_payload2;
  logic [1:0]    occ2;

  logic          bs_valid, bm_ready, bs_ready, bm_valid;
  logic [PW-1:0] bs_payload, bm_payload;
  logic [1:0]    bocc;

  int total = 0;
  int bad   = 0;

  coreaxi4sram_chan_slice #(.PAYLOAD_WIDTH(PW), .MODE(0)) u_m0 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_VALID(bs_valid), .S_READY(bs_ready), .S_PAYLOAD(bs_payload),
    .M_VALID(bm_valid), .M_READY(bm_ready), .M_PAYLOAD(bm_payload),
    .OCCUPANCY(bocc)
  );

  coreaxi4sram_chan_slice #(.PAYLOAD_WIDTH(PW), .MODE(1)) u_m1 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_VALID(s_valid), .S_READY(s_ready1), .S_PAYLOAD(s_payload),
    .M_VALID(m_valid1), .M_READY(m_ready), .M_PAYLOAD(m_payload1),
    .OCCUPANCY(occ1)
  );

  coreaxi4sram_chan_slice #(.PAYLOAD_WIDTH(PW), .MODE(2)) u_m2 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_VALID(s_valid), .S_READY(s_ready2), .S_PAYLOAD(s_payload),
    .M_VALID(m_valid2), .M_READY(m_ready), .M_PAYLOAD(m_payload2),
    .OCCUPANCY(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] q[$];
  logic [PW-1:0] nxt;
  logic [PW-1:0] prev_payload;
  logic          pending;
  logic          stall_prev;
  logic          up, down;
  logic [PW-1:0] bv_pay [4];
  logic          bv_sv  [4];
  logic          bv_mr  [4];

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b1;
    m_ready    = 1'b0;
    s_payload  = 16'h00EE;
    bs_valid   = 1'b0;
    bm_ready   = 1'b0;
    bs_payload = '0;

    // Reset held with S_VALID asserted
    step();
    step();
    chk("rst_s_ready2", s_ready2, 0);
    chk("rst_m_valid2", m_valid2, 0);
    chk("rst_occ2", occ2, 0);
    chk("rst_m_payload2", m_payload2, 0);
    chk("rst_s_ready1", s_ready1, 0);
    chk("rst_m_valid1", m_valid1, 0);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("rel_s_ready2_pre", s_ready2, 0);
    chk("rel_s_ready1_pre", s_ready1, 0);
    step();
    chk("rel_s_ready2_post", s_ready2, 1);
    chk("rel_s_ready1_post", s_ready1, 1);
    chk("rel_m_valid2", m_valid2, 0);

    // Bypass: outputs track inputs combinationally
    bv_sv[0] = 1'b1; bv_mr[0] = 1'b0; bv_pay[0] = 16'h1234;
    bv_sv[1] = 1'b0; bv_mr[1] = 1'b1; bv_pay[1] = 16'hBEEF;
    bv_sv[2] = 1'b1; bv_mr[2] = 1'b1; bv_pay[2] = 16'h0F0F;
    bv_sv[3] = 1'b0; bv_mr[3] = 1'b0; bv_pay[3] = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      bs_valid   = bv_sv[i];
      bm_ready   = bv_mr[i];
      bs_payload = bv_pay[i];
      #1;
      chk("byp_m_valid", bm_valid, bv_sv[i]);
      chk("byp_s_ready", bs_ready, bv_mr[i]);
      chk("byp_payload", bm_payload, bv_pay[i]);
      chk("byp_occ", bocc, 0);
    end

    // Streaming 0x1..0x10 through MODE 1 and MODE 2
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid   = 1'b1;
      s_payload = PW'(i);
      #1;
      chk("str_s_ready1", s_ready1, 1);
      chk("str_s_ready2", s_ready2, 1);
      if (i > 1) begin
        chk("str_m_valid1", m_valid1, 1);
        chk("str_payload1", m_payload1, 32'(i - 1));
        chk("str_m_valid2", m_valid2, 1);
        chk("str_payload2", m_payload2, 32'(i - 1));
      end
      step();
    end
    s_valid = 1'b0;
    #1;
    chk("str_last1", m_payload1, 16'h10);
    chk("str_last2", m_payload2, 16'h10);
    chk("str_last_valid2", m_valid2, 1);
    step();
    chk("str_idle_valid1", m_valid1, 0);
    chk("str_idle_valid2", m_valid2, 0);

    // Backpressure on MODE 2
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_payload = 16'h000A;
    #1;
    chk("bp_ready_a", s_ready2, 1);
    step();
    s_payload = 16'h000B;
    #1;
    chk("bp_ready_b", s_ready2, 1);
    chk("bp_occ_1", occ2, 1);
    step();
    s_payload = 16'h000C;
    #1;
    chk("bp_ready_c", s_ready2, 0);
    chk("bp_occ_2", occ2, 2);
    chk("bp_hold_a", m_payload2, 16'h000A);
    step();
    chk("bp_still_full", s_ready2, 0);
    chk("bp_still_a", m_payload2, 16'h000A);
    chk("bp_still_valid", m_valid2, 1);
    m_ready = 1'b1;
    #1;
    chk("bp_deliver_a", m_payload2, 16'h000A);
    step();
    chk("bp_deliver_b", m_payload2, 16'h000B);
    chk("bp_occ_after_a", occ2, 1);
    chk("bp_ready_after_a", s_ready2, 1);
    step();
    s_valid = 1'b0;
    #1;
    chk("bp_deliver_c", m_payload2, 16'h000C);
    chk("bp_valid_c", m_valid2, 1);
    step();
    chk("bp_empty", m_valid2, 0);
    chk("bp_occ_0", occ2, 0);
    step();

    // Random stress on MODE 2 starting from OCCUPANCY = 1
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_payload = 16'h0100;
    q.push_back(16'h0100);
    step();
    chk("rs_start_occ", occ2, 1);
    nxt        = 16'h0101;
    pending    = 1'b0;
    stall_prev = 1'b0;
    prev_payload = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        s_valid   = 1'($urandom_range(0, 1));
        s_payload = nxt;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        chk("rs_stable_valid", m_valid2, 1);
        chk("rs_stable_payload", m_payload2, prev_payload);
      end
      chk("rs_occ", occ2, q.size());
      up   = s_valid & s_ready2;
      down = m_valid2 & m_ready;
      if (down) begin
        if (q.size() == 0) chk("rs_underflow", m_valid2, 0);
        else chk("rs_order", m_payload2, q.pop_front());
      end
      if (up) begin
        q.push_back(s_payload);
        nxt++;
        pending = 1'b0;
      end else begin
        pending = s_valid;
      end
      stall_prev   = m_valid2 & ~m_ready;
      prev_payload = m_payload2;
      step();
    end
    // Drain whatever is left
    m_ready = 1'b1;
    if (pending) begin
      while (!s_ready2) begin
        #1;
        if (m_valid2) begin
          if (q.size() == 0) chk("rs_underflow", m_valid2, 0);
          else chk("rs_order", m_payload2, q.pop_front());
        end
        step();
      end
      q.push_back(s_payload);
      step();
      s_valid = 1'b0;
      if (q.size() > 2) void'(q.pop_front());
    end
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (m_valid2) begin
        if (q.size() == 0) chk("rs_underflow", m_valid2, 0);
        else chk("rs_order", m_payload2, q.pop_front());
      end
      step();
    end
    chk("rs_drained_occ", occ2, 0);
    chk("rs_drained_sb", q.size(), 0);

    // Reset mid-operation with MODE 2 full
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_payload = 16'h0077;
    step();
    s_payload = 16'h0078;
    step();
    s_valid = 1'b0;
    #1;
    chk("mid_occ_full", occ2, 2);
    rst_n    = 1'b0;
    bs_valid = 1'b1;
    bm_ready = 1'b1;
    bs_payload = 16'h3C3C;
    #1;
    chk("mid_m_valid", m_valid2, 0);
    chk("mid_occ", occ2, 0);
    chk("mid_payload", m_payload2, 0);
    chk("mid_s_ready", s_ready2, 0);
    chk("mid_byp_valid", bm_valid, 1);
    chk("mid_byp_ready", bs_ready, 1);
    chk("mid_byp_payload", bm_payload, 16'h3C3C);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_ready_back", s_ready2, 1);
    m_ready   = 1'b1;
    s_valid   = 1'b1;
    s_payload = 16'h0055;
    #1;
    chk("mid_still_empty", m_valid2, 0);
    step();
    s_valid = 1'b0;
    #1;
    chk("mid_first_valid", m_valid2, 1);
    chk("mid_first_beat", m_payload2, 16'h0055);
    step();
    chk("mid_done_valid", m_valid2, 0);
    chk("mid_done_occ", occ2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coreaxi4sram_chan_slice.md
Name: coreaxi4sram_chan_slice

Overview:
- Parametrised single-channel AXI4 register slice placed between the AXI4 slave ports and the slave interface in CoreAXI4SRAM.
- One instance per channel (AW, W, AR, R, B); the payload is the channel's concatenated fields.
- Generalises the fixed pass-through/strobe latching of the current slave interface into a full valid/ready register stage.
- MODE selects bypass, forward-registered, or fully registered (skid) timing, so timing closure is tunable per channel without changing the protocol.

Parameters:
- PAYLOAD_WIDTH, 73, bit width of the channel payload (default = W channel: 64 data + 8 strobe + 1 last).
- MODE, 2, 0 = bypass (combinational), 1 = forward-registered, 2 = fully registered skid buffer.

Ports:
- ACLK  input  1  clock; all state changes on the rising edge.
- ARESETN  input  1  asynchronous active-low reset.
- S_VALID  input  1  upstream valid.
- S_READY  output  1  upstream ready.
- S_PAYLOAD  input  PAYLOAD_WIDTH  upstream payload.
- M_VALID  output  1  downstream valid.
- M_READY  input  1  downstream ready.
- M_PAYLOAD  output  PAYLOAD_WIDTH  downstream payload.
- OCCUPANCY  output  2  beats currently held, range 0..2; always 0 in MODE 0.

Behaviour:
- Handshakes:
  - Upstream transfer = S_VALID & S_READY at a rising edge.
  - Downstream transfer = M_VALID & M_READY at a rising edge.
  - Beats are delivered in order; no beat is lost or duplicated.
- Reset (ARESETN = 0, asynchronous, MODE 1/2):
  - M_VALID = 0, M_PAYLOAD = 0, OCCUPANCY = 0, S_READY = 0, all internal valids cleared.
  - An init flag is cleared on reset and set on the first ACLK edge after deassertion; S_READY is forced 0 until it is set.
  - Beats held when reset asserts are discarded.
- MODE 0 (bypass):
  - M_VALID = S_VALID, S_READY = M_READY, M_PAYLOAD = S_PAYLOAD, all combinational.
  - No state; reset has no effect.
- MODE 1 (forward-registered), one register stage:
  - S_READY = init & (~M_VALID | M_READY), a combinational ready path.
  - On an upstream transfer, the register loads S_PAYLOAD and M_VALID = 1 next cycle.
  - On a downstream transfer with no upstream transfer, M_VALID = 0 next cycle.
  - Latency 1 cycle; throughput 1 beat/cycle under continuous M_READY.
- MODE 2 (skid), main register plus skid register:
  - S_READY = init & ~skid_valid; it depends only on registers, so there is no combinational path in either direction.
  - States, with OCCUPANCY equal to the count:
    - EMPTY (0): upstream transfer -> main, go to ONE.
    - ONE (1): simultaneous up and down transfers -> main reloads, stay in ONE. Down only -> EMPTY. Up only while M_READY = 0 -> beat goes to skid, go to FULL.
    - FULL (2): S_READY = 0. Down transfer -> skid moves to main, go to ONE.
  - M_VALID = main_valid; M_PAYLOAD = main register.
  - Latency 1 cycle; throughput 1 beat/cycle.
- Stability: while M_VALID = 1 and M_READY = 0, M_PAYLOAD and M_VALID are held unchanged (AXI4 rule).
- Upstream behaviour relied on: S_VALID, once asserted, is not withdrawn before S_READY; the block does not check this.
- Payload registers carry no reset-dependent behaviour beyond clearing to 0.

Test Plan:
- Reset: MODE 2, hold ARESETN = 0 with S_VALID = 1 -> S_READY = 0, M_VALID = 0, OCCUPANCY = 0. Release -> S_READY = 1 after exactly one ACLK edge.
- Streaming: MODE 1 and MODE 2, M_READY = 1, send payloads 0x1..0x10 back-to-back -> M_PAYLOAD = 0x1 one cycle after the first upstream transfer, then one beat per cycle in order, no bubbles.
- Backpressure: MODE 2, M_READY = 0, send 0xA, 0xB, 0xC -> OCCUPANCY reaches 2, S_READY = 0 with 0xC stalled, M_PAYLOAD holds 0xA. Raise M_READY -> 0xA, 0xB, 0xC delivered on consecutive cycles.
- Random stress: MODE 2, OCCUPANCY = 1, random S_VALID and M_READY for 10k cycles -> scoreboard shows in-order, lossless delivery. M_PAYLOAD is stable whenever M_VALID & ~M_READY.
- Bypass: MODE 0 -> M_VALID, S_READY and M_PAYLOAD track the inputs within the same cycle; OCCUPANCY = 0 throughout.
- Reset mid-operation: MODE 2, OCCUPANCY = 2, pulse ARESETN low for 1 cycle -> immediate M_VALID = 0, OCCUPANCY = 0. Next beat 0x55 after release is the first beat delivered.
